// File: rtl/pe_ctrl_pkg.sv
// Shared types and default widths for the pe_array sequencer.
// Imported by the interface, address generator and top level.
package pe_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 10;
  localparam int TILE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    TAIL,
    WAIT,
    OUT,
    DONE
  } pe_ctrl_state_t;

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Job config, status, SRAM read and pe_array control bundle.
// master = sequencer side, slave = job issuer / SRAM / pe_array side.
interface pe_array_ctrl_if;
  import pe_ctrl_pkg::*;

  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [TILE_W-1:0] cfg_tiles;
  logic [ADDR_W-1:0] cfg_act_base;
  logic [ADDR_W-1:0] cfg_wet_base;
  logic [7:0]        cfg_shift;

  logic              busy;
  logic              done;
  logic              tile_valid;
  logic [TILE_W-1:0] tile_idx;

  logic              act_rd_en;
  logic [ADDR_W-1:0] act_rd_addr;
  logic              wet_rd_en;
  logic [ADDR_W-1:0] wet_rd_addr;

  logic              PE_mac_enable;
  logic              PE_clear_acc;
  logic [7:0]        PE_res_shift_num;

  modport master (
    input  start, cfg_len, cfg_tiles,
    input  cfg_act_base, cfg_wet_base, cfg_shift,
    output busy, done, tile_valid, tile_idx,
    output act_rd_en, act_rd_addr,
    output wet_rd_en, wet_rd_addr,
    output PE_mac_enable, PE_clear_acc,
    output PE_res_shift_num
  );

  modport slave (
    output start, cfg_len, cfg_tiles,
    output cfg_act_base, cfg_wet_base, cfg_shift,
    input  busy, done, tile_valid, tile_idx,
    input  act_rd_en, act_rd_addr,
    input  wet_rd_en, wet_rd_addr,
    input  PE_mac_enable, PE_clear_acc,
    input  PE_res_shift_num
  );

endinterface

// File: rtl/pe_ctrl_addr_gen.sv
// k / tile counters and running SRAM read addresses.
// Addresses are the registered read-address outputs themselves.
module pe_ctrl_addr_gen
  import pe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              mac_step,
  input  logic              next_tile,
  input  logic [ADDR_W-1:0] act_base_i,
  input  logic [ADDR_W-1:0] wet_base_i,
  input  logic [ADDR_W-1:0] wet_rewind_i,
  output logic [LEN_W-1:0]  k_o,
  output logic [TILE_W-1:0] t_o,
  output logic [ADDR_W-1:0] act_addr_o,
  output logic [ADDR_W-1:0] wet_addr_o
);

  logic [LEN_W-1:0]  k_q, k_d;
  logic [TILE_W-1:0] t_q, t_d;
  logic [ADDR_W-1:0] act_q, act_d;
  logic [ADDR_W-1:0] wet_q, wet_d;

  // act runs across tiles; wet rewinds to its base every tile
  always_comb begin
    k_d   = k_q;
    t_d   = t_q;
    act_d = act_q;
    wet_d = wet_q;
    if (load) begin
      k_d   = '0;
      t_d   = '0;
      act_d = act_base_i;
      wet_d = wet_base_i;
    end else begin
      if (step) begin
        act_d = act_q + 1'b1;
        wet_d = wet_q + 1'b1;
      end
      if (mac_step)
        k_d = k_q + 1'b1;
      if (next_tile) begin
        t_d   = t_q + 1'b1;
        k_d   = '0;
        wet_d = wet_rewind_i;
      end
    end
  end

  // counter and address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q   <= '0;
      t_q   <= '0;
      act_q <= '0;
      wet_q <= '0;
    end else begin
      k_q   <= k_d;
      t_q   <= t_d;
      act_q <= act_d;
      wet_q <= wet_d;
    end
  end

  assign k_o        = k_q;
  assign t_o        = t_q;
  assign act_addr_o = act_q;
  assign wet_addr_o = wet_q;

endmodule

// File: rtl/pe_array_ctrl.sv
// Tile sequencer for pe_array: FSM, config latches, output decode.
// All control outputs are registered alongside the state.
module pe_array_ctrl
  import pe_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  pe_array_ctrl_if.master bus
);

  pe_ctrl_state_t state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [ADDR_W-1:0] wet_base_q, wet_base_d;
  logic [7:0]        shift_q, shift_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tv_q, tv_d;
  logic [TILE_W-1:0] idx_q, idx_d;
  logic              rd_en_q, rd_en_d;
  logic              mac_q, mac_d;
  logic              clr_q, clr_d;

  logic [LEN_W-1:0]  k;
  logic [TILE_W-1:0] t;
  logic [LEN_W:0]    k_nxt;
  logic              accept;
  logic              last_k;
  logic              last_tile;
  logic              addr_step;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_k    = (k == len_q - 1'b1);
  assign last_tile = (t == tiles_q - 1'b1);
  assign addr_step = ((state_q == CLEAR) && (len_q != '0))
                   || ((state_q == MAC) && !last_k);

  pe_ctrl_addr_gen u_addr (
    .clk          (clk),
    .reset        (reset),
    .load         (accept),
    .step         (addr_step),
    .mac_step     (state_q == MAC),
    .next_tile    (state_q == OUT),
    .act_base_i   (bus.cfg_act_base),
    .wet_base_i   (bus.cfg_wet_base),
    .wet_rewind_i (wet_base_q),
    .k_o          (k),
    .t_o          (t),
    .act_addr_o   (bus.act_rd_addr),
    .wet_addr_o   (bus.wet_rd_addr)
  );

  // next-state: one CLEAR, K MACs, TAIL, WAIT, OUT per tile
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CLEAR;
      CLEAR:   state_d = (len_q == '0) ? TAIL : MAC;
      MAC:     if (last_k) state_d = TAIL;
      TAIL:    state_d = WAIT;
      WAIT:    state_d = OUT;
      OUT:     state_d = last_tile ? DONE : CLEAR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // config latched once per job; T of 0 runs one tile
  always_comb begin
    len_d      = len_q;
    tiles_d    = tiles_q;
    wet_base_d = wet_base_q;
    shift_d    = shift_q;
    if (accept) begin
      len_d      = bus.cfg_len;
      tiles_d    = (bus.cfg_tiles == '0) ? TILE_W'(1)
                                         : bus.cfg_tiles;
      wet_base_d = bus.cfg_wet_base;
      shift_d    = bus.cfg_shift;
    end
  end

  // outputs decoded from the state being entered
  always_comb begin
    k_nxt   = (state_q == MAC) ? ({1'b0, k} + 1'b1) : '0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    tv_d    = (state_d == OUT);
    idx_d   = (state_d == OUT) ? t : idx_q;
    clr_d   = (state_d == CLEAR);
    mac_d   = (state_d == MAC) || (state_d == TAIL);
    rd_en_d = (state_d == CLEAR)
            || ((state_d == MAC)
                && ((k_nxt + 1'b1) < {1'b0, len_q}));
  end

  // state, config and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      tiles_q    <= '0;
      wet_base_q <= '0;
      shift_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tv_q       <= 1'b0;
      idx_q      <= '0;
      rd_en_q    <= 1'b0;
      mac_q      <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      tiles_q    <= tiles_d;
      wet_base_q <= wet_base_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tv_q       <= tv_d;
      idx_q      <= idx_d;
      rd_en_q    <= rd_en_d;
      mac_q      <= mac_d;
      clr_q      <= clr_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.tile_valid       = tv_q;
  assign bus.tile_idx         = idx_q;
  assign bus.act_rd_en        = rd_en_q;
  assign bus.wet_rd_en        = rd_en_q;
  assign bus.PE_mac_enable    = mac_q;
  assign bus.PE_clear_acc     = clr_q;
  assign bus.PE_res_shift_num = shift_q;

endmodule
